// File: rtl/axi_sram_slave_pkg.sv
// Shared encodings for the AXI SRAM responder: FSM states, burst types and response codes.
package axi_sram_slave_pkg;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_BEAT = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Byte stride of one beat for a given AxSIZE.
  function automatic logic [31:0] beat_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

endpackage

// File: rtl/axi_slv_addr_gen.sv
// Next-beat address for one AXI channel: FIXED holds, INCR and all other types step by 1<<size.
module axi_slv_addr_gen
  import axi_sram_slave_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  always_comb begin
    next_addr = addr + beat_bytes(size);
    if (burst == BURST_FIXED) begin
      next_addr = addr;
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style SRAM responder with independent read and write engines.
// Optional random ready/valid stalls are enabled by defining AXI_SLV_STALL_EN.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter logic [31:0] INIT_VAL   = 32'h0,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [3:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned Words = 1 << ADDR_W;

  logic [31:0] mem [Words];

  function automatic logic [ADDR_W-1:0] widx(input logic [31:0] a);
    return a[ADDR_W+1:2];
  endfunction

  logic stall;
`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr_q;
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= STALL_SEED;
    else     lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end
  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{awlock, awcache, awprot, arlock, arcache, arprot, wid, wlast, STALL_SEED};

  // Read engine
  rd_state_e   rd_state_q;
  logic        ar_ready_q, r_valid_q, r_shown_q;
  logic [31:0] r_addr_q, r_next;
  logic [3:0]  r_len_q, r_cnt_q;
  logic [2:0]  r_size_q;
  logic [1:0]  r_burst_q;
  logic        ar_fire, r_fire;

  assign arready = ar_ready_q & ~stall;
  // Once a beat has been shown it stays visible until accepted.
  assign rvalid  = r_valid_q & (r_shown_q | ~stall);
  assign rresp   = RESP_OKAY;
  assign ar_fire = arvalid & arready;
  assign r_fire  = rvalid & rready;

  axi_slv_addr_gen u_rd_addr_gen (
    .addr      (r_addr_q),
    .size      (r_size_q),
    .burst     (r_burst_q),
    .next_addr (r_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= R_IDLE;
      ar_ready_q <= 1'b1;
      r_valid_q  <= 1'b0;
      r_shown_q  <= 1'b0;
      rlast      <= 1'b0;
      rdata      <= 32'h0;
      rid        <= 4'h0;
      r_addr_q   <= 32'h0;
      r_len_q    <= 4'h0;
      r_cnt_q    <= 4'h0;
      r_size_q   <= 3'h0;
      r_burst_q  <= 2'h0;
    end else begin
      unique case (rd_state_q)
        R_IDLE: begin
          if (ar_fire) begin
            r_addr_q   <= araddr;
            r_len_q    <= arlen;
            r_size_q   <= arsize;
            r_burst_q  <= arburst;
            rid        <= arid;
            r_cnt_q    <= 4'h0;
            rdata      <= mem[widx(araddr)];
            rlast      <= (arlen == 4'h0);
            r_valid_q  <= 1'b1;
            ar_ready_q <= 1'b0;
            rd_state_q <= R_BEAT;
          end
        end
        R_BEAT: begin
          if (r_fire) begin
            r_shown_q <= 1'b0;
            if (rlast) begin
              r_valid_q  <= 1'b0;
              rlast      <= 1'b0;
              ar_ready_q <= 1'b1;
              rd_state_q <= R_IDLE;
            end else begin
              r_cnt_q  <= r_cnt_q + 4'd1;
              r_addr_q <= r_next;
              rdata    <= mem[widx(r_next)];
              rlast    <= (r_cnt_q + 4'd1 == r_len_q);
            end
          end else if (rvalid) begin
            r_shown_q <= 1'b1;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  // Write engine
  wr_state_e   wr_state_q;
  logic        aw_ready_q, w_ready_q, b_valid_q;
  logic [31:0] w_addr_q, w_next;
  logic [3:0]  w_len_q, w_cnt_q, w_id_q;
  logic [2:0]  w_size_q;
  logic [1:0]  w_burst_q;
  logic        aw_fire, w_fire;

  assign awready = aw_ready_q & ~stall;
  assign wready  = w_ready_q & ~stall;
  assign bvalid  = b_valid_q;
  assign bresp   = RESP_OKAY;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  axi_slv_addr_gen u_wr_addr_gen (
    .addr      (w_addr_q),
    .size      (w_size_q),
    .burst     (w_burst_q),
    .next_addr (w_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= W_IDLE;
      aw_ready_q <= 1'b1;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      bid        <= 4'h0;
      w_id_q     <= 4'h0;
      w_addr_q   <= 32'h0;
      w_len_q    <= 4'h0;
      w_cnt_q    <= 4'h0;
      w_size_q   <= 3'h0;
      w_burst_q  <= 2'h0;
    end else begin
      unique case (wr_state_q)
        W_IDLE: begin
          if (aw_fire) begin
            w_addr_q   <= awaddr;
            w_len_q    <= awlen;
            w_size_q   <= awsize;
            w_burst_q  <= awburst;
            w_id_q     <= awid;
            w_cnt_q    <= 4'h0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b1;
            wr_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_cnt_q  <= w_cnt_q + 4'd1;
            w_addr_q <= w_next;
            // Burst length comes from awlen alone; wlast is not trusted.
            if (w_cnt_q == w_len_q) begin
              w_ready_q  <= 1'b0;
              b_valid_q  <= 1'b1;
              bid        <= w_id_q;
              wr_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Words; i++) begin
        mem[ADDR_W'(i)] <= INIT_VAL;
      end
    end else if (w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx(w_addr_q)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: directed scenarios plus random bursts against a word model.
module tb_axi_sram_slave;

  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned WORDS    = 1 << ADDR_W;
  localparam logic [31:0] INIT_VAL = 32'h5A5A_C3C3;
  localparam int          TMO      = 1000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  awid, wid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  awlen, arlen, wstrb, awcache, arcache;
  logic [2:0]  awsize, arsize, awprot, arprot;
  logic [1:0]  awburst, arburst, awlock, arlock, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;

  axi_sram_slave #(.ADDR_W(ADDR_W), .INIT_VAL(INIT_VAL), .STALL_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic to_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out waiting for handshake (t=%0t)", name, $time);
  endtask

  // Reference model: sparse word array, unwritten words read as INIT_VAL.
  logic [31:0] model [int unsigned];

  function automatic int unsigned widx(input logic [31:0] a);
    return (a / 4) % WORDS;
  endfunction

  function automatic logic [31:0] baddr(input logic [31:0] a, input logic [2:0] size,
                                        input logic [1:0] burst, input int i);
    if (burst == 2'b00) return a;
    return a + 32'(i) * (32'd1 << size);
  endfunction

  function automatic logic [31:0] m_rd(input int unsigned idx);
    return model.exists(idx) ? model[idx] : INIT_VAL;
  endfunction

  task automatic m_wr(input int unsigned idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] cur;
    cur = m_rd(idx);
    for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = d[8*b +: 8];
    model[idx] = cur;
  endtask

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic        last;
  } rexp_t;

  rexp_t      r_exp[$];
  logic [3:0] b_exp[$];
  int         r_seen    = 0;
  int         hold_at   = -1;
  int         hold_left = 0;
  bit         rnd       = 1'b0;

  // Ready drivers: optional randomisation and a scripted rready hold.
  always @(posedge clk) begin
    #1;
    if (hold_left > 0 && r_seen == hold_at) begin
      rready = 1'b0;
      hold_left--;
    end else if (rnd) rready = ($urandom % 4) != 0;
    else rready = 1'b1;
    bready = rnd ? (($urandom % 3) != 0) : 1'b1;
  end

  // Monitor: pops the scoreboard on every R/B handshake and checks stalled R stays put.
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic [3:0]  hold_id;
  logic        hold_l;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        chk("r_hold_valid", 32'(rvalid), 32'd1);
        chk("r_hold_data", rdata, hold_d);
        chk("r_hold_last", 32'(rlast), 32'(hold_l));
        chk("r_hold_id", 32'(rid), 32'(hold_id));
      end
      if (rvalid && rready) begin
        if (r_exp.size() == 0) begin
          chk("r_unexpected_beat", 32'(rvalid), 32'd0);
        end else begin
          rexp_t e;
          e = r_exp.pop_front();
          chk("rdata", rdata, e.data);
          chk("rid", 32'(rid), 32'(e.id));
          chk("rlast", 32'(rlast), 32'(e.last));
          chk("rresp", 32'(rresp), 32'd0);
        end
        r_seen++;
      end
      hold_v  = rvalid && !rready;
      hold_d  = rdata;
      hold_id = rid;
      hold_l  = rlast;
      if (bvalid && bready) begin
        if (b_exp.size() == 0) begin
          chk("b_unexpected", 32'(bvalid), 32'd0);
        end else begin
          chk("bid", 32'(bid), 32'(b_exp.pop_front()));
          chk("bresp", 32'(bresp), 32'd0);
        end
      end
    end
  end

  logic [31:0] wd [16];
  logic [3:0]  ws [16];

  task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int k;
    for (int i = 0; i <= int'(len); i++) begin
      rexp_t e;
      e.id   = id;
      e.data = m_rd(widx(baddr(addr, size, burst, i)));
      e.last = (i == int'(len));
      r_exp.push_back(e);
    end
    @(posedge clk); #1;
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
    k = 0;
    @(negedge clk);
    while (!arready && k < TMO) begin k++; @(negedge clk); end
    if (!arready) to_fail("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wr_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int k;
    b_exp.push_back(id);
    @(posedge clk); #1;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
    k = 0;
    @(negedge clk);
    while (!awready && k < TMO) begin k++; @(negedge clk); end
    if (!awready) to_fail("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      if (rnd) begin
        wvalid = 1'b0;
        repeat ($urandom % 3) begin @(posedge clk); #1; end
      end
      wvalid = 1'b1; wid = id; wdata = wd[i]; wstrb = ws[i]; wlast = (i == int'(len));
      k = 0;
      @(negedge clk);
      while (!wready && k < TMO) begin k++; @(negedge clk); end
      if (!wready) to_fail("w_handshake");
      @(posedge clk); #1;
      m_wr(widx(baddr(addr, size, burst, i)), wd[i], ws[i]);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((r_exp.size() != 0 || b_exp.size() != 0) && k < 4 * TMO) begin
      k++;
      @(negedge clk);
    end
    if (r_exp.size() != 0 || b_exp.size() != 0) to_fail("drain");
  endtask

  task automatic chk_reset_outputs(input string tag);
    @(negedge clk);
`ifndef AXI_SLV_STALL_EN
    chk({tag, "_arready"}, 32'(arready), 32'd1);
    chk({tag, "_awready"}, 32'(awready), 32'd1);
`endif
    chk({tag, "_wready"}, 32'(wready), 32'd0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    chk({tag, "_bvalid"}, 32'(bvalid), 32'd0);
    chk({tag, "_rlast"}, 32'(rlast), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_rid_bid"}, 32'({rid, bid}), 32'd0);
    chk({tag, "_resp"}, 32'({rresp, bresp}), 32'd0);
  endtask

  initial begin
    int k;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    awlock = '0; awcache = '0; awprot = '0; arlock = '0; arcache = '0; arprot = '0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    rready = 1'b1; bready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset_outputs("reset");

    // 16-beat INCR write then read-back with the same ID.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hA5A5_0000 + 32'(i); ws[i] = 4'hF; end
    wr_burst(4'h3, 32'h100, 4'd15, 3'd2, 2'b01);
    wait_drain();
    rd_burst(4'h3, 32'h100, 4'd15, 3'd2, 2'b01);
    wait_drain();

    // Byte-lane write merges into a preloaded word.
    wd[0] = 32'h1122_3344; ws[0] = 4'hF;
    wr_burst(4'h5, 32'h200, 4'd0, 3'd2, 2'b01);
    wait_drain();
    wd[0] = 32'h0000_AB00; ws[0] = 4'b0010;
    wr_burst(4'h5, 32'h200, 4'd0, 3'd2, 2'b01);
    wait_drain();
    chk("model_byte_merge", m_rd(widx(32'h200)), 32'h1122_AB44);
    rd_burst(4'h5, 32'h200, 4'd0, 3'd2, 2'b01);
    wait_drain();

    // Hold rready low for three cycles while beat 5 is presented.
    hold_at   = r_seen + 4;
    hold_left = 3;
    rd_burst(4'h9, 32'h100, 4'd15, 3'd2, 2'b01);
    wait_drain();
    chk("hold_consumed", 32'(hold_left), 32'd0);
    hold_at = -1;

    // FIXED read alongside an independent write.
    wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
    wr_burst(4'h1, 32'h300, 4'd0, 3'd2, 2'b01);
    wait_drain();
    wd[0] = 32'h0BAD_F00D; wd[1] = 32'h1234_5678; ws[0] = 4'hF; ws[1] = 4'hF;
    fork
      rd_burst(4'h6, 32'h300, 4'd3, 3'd2, 2'b00);
      wr_burst(4'h7, 32'h400, 4'd1, 3'd2, 2'b01);
    join
    wait_drain();
    rd_burst(4'h7, 32'h400, 4'd1, 3'd2, 2'b01);
    wait_drain();

    // 32-bit address overflow and index aliasing of the upper address bits.
    wd[0] = 32'hCAFE_0001; wd[1] = 32'hCAFE_0002; ws[0] = 4'hF; ws[1] = 4'hF;
    wr_burst(4'h2, 32'hFFFF_FFFC, 4'd1, 3'd2, 2'b01);
    wait_drain();
    rd_burst(4'h2, 32'h0000_0FFC, 4'd1, 3'd2, 2'b01);
    wait_drain();

    // Reset in the middle of a read burst.
    k = r_seen;
    rd_burst(4'hB, 32'h100, 4'd15, 3'd2, 2'b01);
    begin
      int t = 0;
      while (r_seen < k + 7 && t < TMO) begin t++; @(negedge clk); end
      if (r_seen < k + 7) to_fail("mid_burst_beats");
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    r_exp.delete();
    model.delete();
    chk_reset_outputs("midreset");
    rd_burst(4'hC, 32'h100, 4'd0, 3'd2, 2'b01);
    wait_drain();

    // Random bursts with random ready/valid timing.
    rnd = 1'b1;
    for (int n = 0; n < 100; n++) begin
      logic [2:0]  sz;
      logic [31:0] a;
      sz = 3'($urandom_range(0, 2));
      a  = (($urandom % 4) == 0) ? $urandom : 32'($urandom_range(0, 32'h7FF));
      a  = a & ~((32'd1 << sz) - 32'd1);
      if ($urandom % 2) begin
        for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        wr_burst(4'($urandom), a, 4'($urandom), sz, 2'($urandom));
      end else begin
        rd_burst(4'($urandom), a, 4'($urandom), sz, 2'($urandom));
      end
      wait_drain();
    end
    rnd = 1'b0;
    repeat (5) @(negedge clk);
    chk("r_queue_empty", 32'(r_exp.size()), 32'd0);
    chk("b_queue_empty", 32'(b_exp.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
